// File: rtl/fishing_pkg.sv
// Shared definitions for the fishing scene: line-state encoding, scene
// geometry, animation timing and the 8-bit RGB palette.
package fishing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASTING = 3'd1,
    ST_WAITING = 3'd2,
    ST_BITE    = 3'd3,
    ST_CAUGHT  = 3'd4
  } line_state_t;

  // Horizontal visible window and the last line of a frame
  localparam logic [9:0] H_ACT_START = 10'd144;
  localparam logic [9:0] H_ACT_END   = 10'd784;
  localparam logic [9:0] V_LAST      = 10'd524;

  // Scene geometry
  localparam logic [9:0] WATER_V    = 10'd259;
  localparam logic [9:0] LINE_TOP   = 10'd35;
  localparam logic [9:0] FISH_Y     = 10'd400;
  localparam logic [9:0] FISH_W     = 10'd32;
  localparam logic [9:0] FISH_H     = 10'd16;
  localparam logic [9:0] FISH_SPEED = 10'd2;
  localparam logic [9:0] BOB_X      = 10'd464;
  localparam logic [9:0] BOB_SIZE   = 10'd8;
  localparam logic [9:0] CAST_START = 10'd200;
  localparam logic [9:0] CAST_STEP  = 10'd4;
  localparam logic [9:0] NEAR_DIST  = 10'd64;

  // Frame-count timing; one shared timer wide enough for the longest wait
  localparam int         TMR_W      = 7;
  localparam int         BITE_WAIT  = 120;
  localparam int         BITE_WIN   = 60;
  localparam int         CATCH_HOLD = 60;
  localparam logic [6:0] WAIT_LAST  = 7'(BITE_WAIT - 1);
  localparam logic [6:0] WIN_LAST   = 7'(BITE_WIN - 1);
  localparam logic [6:0] HOLD_LAST  = 7'(CATCH_HOLD - 1);

  // Palette, RRR_GGG_BB
  localparam logic [7:0] COL_RED    = 8'b111_000_00;
  localparam logic [7:0] COL_ORANGE = 8'b111_100_00;
  localparam logic [7:0] COL_WHITE  = 8'b111_111_11;
  localparam logic [7:0] COL_SKY    = 8'b010_110_11;
  localparam logic [7:0] COL_WATER  = 8'b000_001_10;

  // v within [lo, lo+len); the upper bound is formed in 11 bits so it never wraps
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] len);
    logic [10:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (v >= lo) && ({1'b0, v} < hi);
  endfunction

endpackage

// File: rtl/fish_mover.sv
// Fish horizontal position: ping-pongs between the left edge of the visible
// window and the last column where the whole fish box still fits.
module fish_mover
  import fishing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       respawn,
  output logic [9:0] fish_x,
  output logic       fish_dir   // 1 = moving right
);

  localparam logic [9:0] X_MAX = H_ACT_END - FISH_W;

  logic [10:0] x_fwd, x_back;

  // Candidate positions one step each way, 11 bits wide
  always_comb begin
    x_fwd  = {1'b0, fish_x} + {1'b0, FISH_SPEED};
    x_back = {1'b0, fish_x} - {1'b0, FISH_SPEED};
  end

  // One step per frame; reaching a bound clamps there and turns the fish around
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fish_x   <= H_ACT_START;
      fish_dir <= 1'b1;
    end else if (frame_tick) begin
      if (respawn) begin
        fish_x   <= H_ACT_START;
        fish_dir <= 1'b1;
      end else if (fish_dir) begin
        if (x_fwd >= {1'b0, X_MAX}) begin
          fish_x   <= X_MAX;
          fish_dir <= 1'b0;
        end else begin
          fish_x   <= x_fwd[9:0];
        end
      end else begin
        // fish_x never drops below H_ACT_START, so x_back cannot underflow
        if (x_back <= {1'b0, H_ACT_START}) begin
          fish_x   <= H_ACT_START;
          fish_dir <= 1'b1;
        end else begin
          fish_x   <= x_back[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/scene_renderer.sv
// Fishing scene pixel stage: frame tick detection, button latches, the
// cast/bite/reel line FSM and a priority draw mux into registered RGB.
// Optional BITE_FLASH_EN: bobber flashes red/white every 8 frames while BITE.
module scene_renderer
  import fishing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       sky,
  input  logic       water,
  input  logic       btn_cast,
  input  logic       btn_reel,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic [2:0] fsm_state,
  output logic       catch_pulse
);

  logic [9:0]       vcount_q;
  logic             frame_tick;
  logic             cast_q, reel_q, cast_rise, reel_rise;
  logic             cast_p, reel_p;
  line_state_t      state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [9:0]       bob_y, bob_y_n;
  logic             respawn, catch_n;
  logic [9:0]       fish_x;
  logic             fish_dir;
  logic [10:0]      bob_step, fish_ctr;
  logic             fish_near;
  logic [7:0]       bob_col, pix_n, pix;
  logic             bob_on, fish_on, line_on;

  // Delayed vCount; its 524 -> 0 wrap marks the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vcount_q <= '0;
    else       vcount_q <= vCount;
  end

  assign frame_tick = (vcount_q == V_LAST) && (vCount == 10'd0);
  assign cast_rise  = btn_cast & ~cast_q;
  assign reel_rise  = btn_reel & ~reel_q;

  // Press latches: consumed on frame_tick; an edge in that same clk carries over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cast_q <= 1'b0;
      reel_q <= 1'b0;
      cast_p <= 1'b0;
      reel_p <= 1'b0;
    end else begin
      cast_q <= btn_cast;
      reel_q <= btn_reel;
      if (frame_tick) begin
        cast_p <= cast_rise;
        reel_p <= reel_rise;
      end else begin
        cast_p <= cast_p | cast_rise;
        reel_p <= reel_p | reel_rise;
      end
    end
  end

  fish_mover u_fish (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .respawn    (respawn),
    .fish_x     (fish_x),
    .fish_dir   (fish_dir)
  );

  // Bite test: fish centre strictly within NEAR_DIST of the bobber column
  always_comb begin
    bob_step  = {1'b0, bob_y} + {1'b0, CAST_STEP};
    fish_ctr  = {1'b0, fish_x} + {2'b0, FISH_W[9:1]};
    fish_near = (fish_ctr > ({1'b0, BOB_X} - {1'b0, NEAR_DIST})) &&
                (fish_ctr < ({1'b0, BOB_X} + {1'b0, NEAR_DIST}));
  end

  // Line FSM next state; everything advances only on frame_tick
  always_comb begin
    state_n = state;
    timer_n = timer;
    bob_y_n = bob_y;
    respawn = 1'b0;
    catch_n = 1'b0;
    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (cast_p) begin
            state_n = ST_CASTING;
            bob_y_n = CAST_START;
            timer_n = '0;
          end
        end
        ST_CASTING: begin
          if (bob_step >= {1'b0, WATER_V}) begin
            state_n = ST_WAITING;
            bob_y_n = WATER_V;
            timer_n = '0;
          end else begin
            bob_y_n = bob_step[9:0];
          end
        end
        ST_WAITING: begin
          if (reel_p) begin
            state_n = ST_IDLE;
            timer_n = '0;
          end else if (timer == WAIT_LAST) begin
            timer_n = '0;
            if (fish_near) state_n = ST_BITE;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_BITE: begin
          if (reel_p) begin
            state_n = ST_CAUGHT;
            timer_n = '0;
            catch_n = 1'b1;
          end else if (timer == WIN_LAST) begin
            state_n = ST_WAITING;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_CAUGHT: begin
          if (timer == HOLD_LAST) begin
            state_n = ST_IDLE;
            timer_n = '0;
            respawn = 1'b1;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  // Line FSM registers; catch_pulse lines up with the first CAUGHT clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bob_y       <= CAST_START;
      catch_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bob_y       <= bob_y_n;
      catch_pulse <= catch_n;
    end
  end

  assign fsm_state = state;

`ifdef BITE_FLASH_EN
  logic [3:0] flash_cnt;

  // Free-running frame counter; bit 3 flips every 8 frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           flash_cnt <= '0;
    else if (frame_tick) flash_cnt <= flash_cnt + 4'd1;
  end

  assign bob_col = ((state == ST_BITE) && flash_cnt[3]) ? COL_WHITE : COL_RED;
`else
  assign bob_col = COL_RED;
`endif

  // Draw mux: bobber > fish > line > sky/water > black
  always_comb begin
    bob_on  = (state != ST_IDLE) && in_span(hCount, BOB_X, BOB_SIZE) &&
              in_span(vCount, bob_y, BOB_SIZE);
    fish_on = (state != ST_CAUGHT) && in_span(hCount, fish_x, FISH_W) &&
              in_span(vCount, FISH_Y, FISH_H);
    line_on = (state != ST_IDLE) && (hCount == BOB_X) &&
              (vCount >= LINE_TOP) && (vCount < bob_y);
    pix_n = 8'd0;
    if (bob_on)       pix_n = bob_col;
    else if (fish_on) pix_n = COL_ORANGE;
    else if (line_on) pix_n = COL_WHITE;
    else if (sky)     pix_n = COL_SKY;
    else if (water)   pix_n = COL_WATER;
  end

  // Output colour register, one clk behind the pixel counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix <= 8'd0;
    else       pix <= pix_n;
  end

  assign red   = pix[7:5];
  assign green = pix[4:2];
  assign blue  = pix[1:0];

endmodule

// File: tb/tb_scene_renderer.sv
// Self-checking bench for scene_renderer: frames are compressed to a short
// vCount 524 -> 0 wrap, and a frame-level reference model tracks the scene.
module tb_scene_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hCount, vCount;
  logic       sky, water, btn_cast, btn_reel;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [2:0] fsm_state;
  logic       catch_pulse;

  always #5 clk = ~clk;

  scene_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .hCount      (hCount),
    .vCount      (vCount),
    .sky         (sky),
    .water       (water),
    .btn_cast    (btn_cast),
    .btn_reel    (btn_reel),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .fsm_state   (fsm_state),
    .catch_pulse (catch_pulse)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Counts clks where catch_pulse is high
  always @(negedge clk) if (catch_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  // Scene state per frame: st 0..4 = IDLE,CASTING,WAITING,BITE,CAUGHT
  typedef struct {
    int st; int fx; int dir; int bob; int tmr; int frames; bit cp; bit rp;
  } mdl_t;
  mdl_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One frame of the scene rules
  function automatic mdl_t mstep(mdl_t s);
    mdl_t n;
    bit   resp;
    int   d;
    n = s;
    resp = 0;
    n.frames = s.frames + 1;
    case (s.st)
      0: if (s.cp) begin n.st = 1; n.bob = 200; n.tmr = 0; end
      1: if (s.bob + 4 >= 259) begin n.bob = 259; n.st = 2; n.tmr = 0; end
         else n.bob = s.bob + 4;
      2: if (s.rp) begin n.st = 0; n.tmr = 0; end
         else if (s.tmr == 119) begin
           n.tmr = 0;
           d = s.fx + 16 - 464;
           if (d < 0) d = -d;
           if (d < 64) n.st = 3;
         end else n.tmr = s.tmr + 1;
      3: if (s.rp) begin n.st = 4; n.tmr = 0; end
         else if (s.tmr == 59) begin n.st = 2; n.tmr = 0; end
         else n.tmr = s.tmr + 1;
      default: if (s.tmr == 59) begin n.st = 0; n.tmr = 0; resp = 1; end
         else n.tmr = s.tmr + 1;
    endcase
    if (resp) begin n.fx = 144; n.dir = 1; end
    else if (s.dir == 1) begin
      if (s.fx + 2 >= 752) begin n.fx = 752; n.dir = 0; end else n.fx = s.fx + 2;
    end else begin
      if (s.fx - 2 <= 144) begin n.fx = 144; n.dir = 1; end else n.fx = s.fx - 2;
    end
    n.cp = 0;
    n.rp = 0;
    return n;
  endfunction

  function automatic logic [7:0] exp_pix(mdl_t s, int h, int v, bit sk, bit wt);
    bit active;
    active = (s.st != 0);
    if (active && h >= 464 && h < 472 && v >= s.bob && v < s.bob + 8) begin
`ifdef BITE_FLASH_EN
      if (s.st == 3 && ((s.frames / 8) % 2) == 1) return 8'hFF;
`endif
      return 8'hE0;
    end
    if (s.st != 4 && h >= s.fx && h < s.fx + 32 && v >= 400 && v < 416) return 8'hF0;
    if (active && h == 464 && v >= 35 && v < s.bob) return 8'hFF;
    if (sk) return 8'h5B;
    if (wt) return 8'h06;
    return 8'h00;
  endfunction

  // Would a cast issued now (or carried over from the tick clk) lead to a bite?
  function automatic bit will_bite(mdl_t s, bit late);
    mdl_t t;
    t = s;
    if (late) t = mstep(t);
    t.cp = 1;
    for (int i = 0; i < 145; i++) begin
      t = mstep(t);
      if (t.st == 3) return 1;
    end
    return 0;
  endfunction

  // Compressed frame: vCount holds 524 then wraps to 0 for 4 clks each
  task automatic frame(input bit cast_edge);
    @(negedge clk);
    vCount = 10'd524;
    repeat (4) @(negedge clk);
    vCount = 10'd0;
    if (cast_edge) btn_cast = 1'b1;
    repeat (4) @(negedge clk);
    btn_cast = 1'b0;
    m = mstep(m);
    if (cast_edge) m.cp = 1;
    chk("state", {29'd0, fsm_state}, m.st);
    chk("fish_x", {22'd0, dut.fish_x}, m.fx);
    chk("bob_y", {22'd0, dut.bob_y}, m.bob);
  endtask

  task automatic press(input bit reel);
    @(negedge clk);
    if (reel) btn_reel = 1'b1; else btn_cast = 1'b1;
    repeat (2) @(negedge clk);
    btn_reel = 1'b0;
    btn_cast = 1'b0;
    if (reel) m.rp = 1; else m.cp = 1;
  endtask

  task automatic probe(input string tag, input int h, input int v, input bit sk, input bit wt);
    @(negedge clk);
    hCount = 10'(h); vCount = 10'(v); sky = sk; water = wt;
    @(negedge clk);
    chk(tag, {24'd0, red, green, blue}, {24'd0, exp_pix(m, h, v, sk, wt)});
  endtask

  task automatic rand_probe();
    int h, v;
    case ($urandom_range(3))
      0: begin h = m.fx - 2 + $urandom_range(35); v = 398 + $urandom_range(19); end
      1: begin h = 462 + $urandom_range(11); v = m.bob - 2 + $urandom_range(11); end
      2: begin h = 463 + $urandom_range(2); v = 30 + $urandom_range(240); end
      default: begin h = $urandom_range(799); v = 1 + $urandom_range(522); end
    endcase
    probe("pix_rand", h, v, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  // Idle until a cast is predicted to bite, cast, then run frames up to BITE
  task automatic get_bite(input bit late);
    bit found;
    found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      if (will_bite(m, late)) found = 1;
      else frame(0);
    end
    chk("bite_found", {31'd0, found}, 1);
    if (late) frame(1);
    else begin press(0); frame(0); end
    for (int i = 0; i < 200 && m.st != 3; i++) begin
      if ($urandom_range(7) == 0) press(0);
      frame(0);
      if (i % 20 == 0) rand_probe();
    end
    chk("reach_bite", {29'd0, fsm_state}, 3);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    hCount = 10'd200; vCount = 10'd50; sky = 1'b1; water = 1'b0;
    btn_cast = 1'b0; btn_reel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {24'd0, red, green, blue}, 0);
    chk("rst_state", {29'd0, fsm_state}, 0);
    chk("rst_fish", {22'd0, dut.fish_x}, 144);
    chk("rst_bob", {22'd0, dut.bob_y}, 200);
    chk("rst_pulse", {31'd0, catch_pulse}, 0);
    reset = 1'b0;
    m = '{st: 0, fx: 144, dir: 1, bob: 200, tmr: 0, frames: 0, cp: 0, rp: 0};

    // Fish sweeps with no casting; stray reel presses are ignored in IDLE
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) press(1);
      frame(0);
      if (i == 303) chk("fish_edge", {22'd0, dut.fish_x}, 752);
      if (i == 304) chk("fish_turn", {22'd0, dut.fish_x}, 750);
      if (i % 25 == 0) rand_probe();
    end
    chk("idle_after_sweep", {29'd0, fsm_state}, 0);

    // Cast edge coincident with frame_tick, then catch
    get_bite(1);
    probe("line_bite", 464, 100, 1'b1, 1'b0);
    chk("line_white", {24'd0, red, green, blue}, 8'hFF);
    probe("bob_bite", 466, 262, 1'b0, 1'b1);
    p0 = pulse_cnt;
    repeat ($urandom_range(40)) frame(0);
    press(1);
    frame(0);
    chk("caught", {29'd0, fsm_state}, 4);
    chk("pulse_one", pulse_cnt - p0, 1);
    probe("no_fish_caught", m.fx + 4, 404, 1'b0, 1'b1);
    for (int i = 0; i < 70 && m.st != 0; i++) frame(0);
    chk("caught_to_idle", {29'd0, fsm_state}, 0);
    chk("respawn", {22'd0, dut.fish_x}, 144);
    chk("pulse_still_one", pulse_cnt - p0, 1);

    // Bite missed, back to WAITING, then reel out to IDLE
    p0 = pulse_cnt;
    get_bite(0);
    for (int i = 0; i < 70 && m.st == 3; i++) frame(0);
    chk("bite_timeout", {29'd0, fsm_state}, 2);
    repeat ($urandom_range(50)) frame(0);
    probe("line_wait", 464, 100, 1'b1, 1'b0);
    chk("line_wait_white", {24'd0, red, green, blue}, 8'hFF);
    probe("sky_only", 200, 50, 1'b1, 1'b0);
    chk("sky_col", {24'd0, red, green, blue}, 8'b010_110_11);
    probe("water_only", 600, 300, 1'b0, 1'b1);
    chk("water_col", {24'd0, red, green, blue}, 8'b000_001_10);
    probe("blank", 10, 10, 1'b0, 1'b0);
    chk("blank_col", {24'd0, red, green, blue}, 0);
    press(1);
    frame(0);
    chk("reel_abort", {29'd0, fsm_state}, 0);
    chk("no_pulse", pulse_cnt - p0, 0);

    // Asynchronous reset mid-frame while in BITE
    get_bite(0);
    probe("pre_reset", 200, 50, 1'b1, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("async_rgb", {24'd0, red, green, blue}, 0);
    chk("async_state", {29'd0, fsm_state}, 0);
    chk("async_fish", {22'd0, dut.fish_x}, 144);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
